// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Purpose : bundles the Fetch-stage request, Memory-stage request and external
//           bus signals that connect to mem_port_arbiter.
// Modports:
//   master - arbiter view: takes requests and bus responses in, and drives
//            dones, read data, canMemoryOut, errOut and the bus request fields.
//   slave  - environment view (Fetch/Memory stages and bus), the mirror image.
// Signals : fetchReqIn/fetchAddrIn/fetchDataOut/fetchDoneOut,
//           memReqIn/memWriteIn/memAddrIn/memWdataIn/memRdataOut/memDoneOut,
//           canMemoryOut, errOut,
//           busReqOut/busWriteOut/busAddrOut/busWdataOut,
//           busAckIn/busRespValidIn/busRdataIn.
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              fetchReqIn;
    logic [ADDR_W-1:0] fetchAddrIn;
    logic [DATA_W-1:0] fetchDataOut;
    logic              fetchDoneOut;
    logic              memReqIn;
    logic              memWriteIn;
    logic [ADDR_W-1:0] memAddrIn;
    logic [DATA_W-1:0] memWdataIn;
    logic [DATA_W-1:0] memRdataOut;
    logic              memDoneOut;
    logic              canMemoryOut;
    logic              errOut;
    logic              busReqOut;
    logic              busWriteOut;
    logic [ADDR_W-1:0] busAddrOut;
    logic [DATA_W-1:0] busWdataOut;
    logic              busAckIn;
    logic              busRespValidIn;
    logic [DATA_W-1:0] busRdataIn;

    modport master (
        input  fetchReqIn, fetchAddrIn,
        input  memReqIn, memWriteIn, memAddrIn, memWdataIn,
        input  busAckIn, busRespValidIn, busRdataIn,
        output fetchDataOut, fetchDoneOut,
        output memRdataOut, memDoneOut, canMemoryOut, errOut,
        output busReqOut, busWriteOut, busAddrOut, busWdataOut
    );

    modport slave (
        output fetchReqIn, fetchAddrIn,
        output memReqIn, memWriteIn, memAddrIn, memWdataIn,
        output busAckIn, busRespValidIn, busRdataIn,
        input  fetchDataOut, fetchDoneOut,
        input  memRdataOut, memDoneOut, canMemoryOut, errOut,
        input  busReqOut, busWriteOut, busAddrOut, busWdataOut
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Purpose : shares the single external memory bus port between instruction
//           fetches and Memory-stage loads/stores. Each access is a
//           req/ack handshake followed by a response; data accesses stall
//           the Memory stage through canMemoryOut until they complete.
//           Fetch starvation is bounded by STARVE_LIMIT and a missing bus
//           response is aborted with errOut after TIMEOUT cycles.
// Ports   :
//   clk     - clock, rising edge
//   resetN  - asynchronous active-low reset
//   io_port - mem_port_arbiter_if.master (requests, dones, bus signals)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                 clk,
    input  logic                 resetN,
    mem_port_arbiter_if.master   io_port
);
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_grant_data;
    logic              w_grant_fetch;
    logic              w_resp;
    logic              w_timeout;

    logic              r_owner_data;   // 1 = Memory stage owns the transaction
    logic [ADDR_W-1:0] r_addr;
    logic              r_write;
    logic [DATA_W-1:0] r_wdata;
    logic [SC_W-1:0]   r_starve_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic [DATA_W-1:0] r_fetch_data;
    logic [DATA_W-1:0] r_mem_rdata;
    logic              r_fetch_done;
    logic              r_mem_done;
    logic              r_err;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_data  = 1'b0;
        w_grant_fetch = 1'b0;
        w_resp        = 1'b0;
        w_timeout     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Data normally wins; a waiting fetch gets one grant once
                // STARVE_LIMIT data grants have gone past it.
                if (io_port.memReqIn &&
                    (!io_port.fetchReqIn || (r_starve_cnt < STARVE_MAX))) begin
                    w_grant_data = 1'b1;
                    w_state_nxt  = ST_REQ;
                end else if (io_port.fetchReqIn) begin
                    w_grant_fetch = 1'b1;
                    w_state_nxt   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (io_port.busAckIn) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // A response arriving on the timeout cycle takes priority.
                if (io_port.busRespValidIn) begin
                    w_resp      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_to_cnt == TO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_owner_data <= 1'b0;
            r_addr       <= '0;
            r_write      <= 1'b0;
            r_wdata      <= '0;
            r_starve_cnt <= '0;
            r_to_cnt     <= '0;
            r_fetch_data <= '0;
            r_mem_rdata  <= '0;
            r_fetch_done <= 1'b0;
            r_mem_done   <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_fetch_done <= 1'b0;
            r_mem_done   <= 1'b0;
            r_err        <= 1'b0;

            if (w_grant_data) begin
                r_owner_data <= 1'b1;
                r_addr       <= io_port.memAddrIn;
                r_write      <= io_port.memWriteIn;
                r_wdata      <= io_port.memWdataIn;
                if (io_port.fetchReqIn && (r_starve_cnt != STARVE_MAX))
                    r_starve_cnt <= r_starve_cnt + SC_W'(1);
            end
            if (w_grant_fetch) begin
                r_owner_data <= 1'b0;
                r_addr       <= io_port.fetchAddrIn;
                r_write      <= 1'b0;
                r_wdata      <= '0;
                r_starve_cnt <= '0;
            end

            if ((r_state == ST_REQ) && io_port.busAckIn)
                r_to_cnt <= '0;
            else if ((r_state == ST_WAIT) && !w_resp && !w_timeout)
                r_to_cnt <= r_to_cnt + TO_W'(1);

            // Stores complete like loads but leave memRdataOut untouched.
            if (w_resp || w_timeout) begin
                r_err <= w_timeout;
                if (r_owner_data) begin
                    r_mem_done <= 1'b1;
                    if (!r_write)
                        r_mem_rdata <= w_resp ? io_port.busRdataIn : '0;
                end else begin
                    r_fetch_done <= 1'b1;
                    r_fetch_data <= w_resp ? io_port.busRdataIn : '0;
                end
            end
        end
    end

    assign io_port.busReqOut    = (r_state == ST_REQ);
    assign io_port.busWriteOut  = r_write;
    assign io_port.busAddrOut   = r_addr;
    assign io_port.busWdataOut  = r_wdata;
    assign io_port.fetchDataOut = r_fetch_data;
    assign io_port.fetchDoneOut = r_fetch_done;
    assign io_port.memRdataOut  = r_mem_rdata;
    assign io_port.memDoneOut   = r_mem_done;
    assign io_port.errOut       = r_err;
    // Gated by resetN so the Memory stage is held while reset is asserted.
    assign io_port.canMemoryOut = resetN &&
        (((r_state == ST_IDLE) && !io_port.memReqIn) || r_mem_done);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Purpose : directed bench for mem_port_arbiter with a scoreboard of expected
//           completions (owner, error flag, read data) checked by a monitor.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) pif ();

    mem_port_arbiter #(
        .ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(4), .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .io_port(pif)
    );

    typedef struct packed {
        logic        is_fetch;
        logic        err;
        logic [63:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic push(input logic f, input logic e, input logic [63:0] d);
        exp_t x;
        x.is_fetch = f;
        x.err      = e;
        x.data     = d;
        sb_q.push_back(x);
    endtask

    // Monitor: every completion pops the oldest expectation.
    always @(negedge clk) begin
        if (resetN && (pif.fetchDoneOut || pif.memDoneOut)) begin
            exp_t e;
            chk("dones_exclusive", {63'd0, pif.fetchDoneOut & pif.memDoneOut}, 64'd0);
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("done_owner", {63'd0, pif.fetchDoneOut}, {63'd0, e.is_fetch});
                chk("done_err", {63'd0, pif.errOut}, {63'd0, e.err});
                chk("done_data", e.is_fetch ? pif.fetchDataOut : pif.memRdataOut, e.data);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // Waits for busReqOut, holds ack for ack_dly cycles, answers resp_dly
    // cycles into WAIT, and returns at the negedge where done should show.
    task automatic bus_txn(input int ack_dly, input int resp_dly, input logic [63:0] rdata,
                           input bit drop_mem, input bit drop_fetch,
                           output logic [63:0] addr, output logic wr,
                           output logic [63:0] wd, output int hold);
        int guard = 0;
        bit stable = 1'b1;
        addr = '0; wr = 1'b0; wd = '0; hold = 0;
        while (!pif.busReqOut && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!pif.busReqOut) begin
            chk("req_wait_timeout", 64'd0, 64'd1);
            return;
        end
        addr = pif.busAddrOut; wr = pif.busWriteOut; wd = pif.busWdataOut; hold = 1;
        for (int i = 0; i < ack_dly; i++) begin
            @(negedge clk);
            if (pif.busReqOut) hold++;
            if (pif.busAddrOut !== addr || pif.busWriteOut !== wr || pif.busWdataOut !== wd)
                stable = 1'b0;
        end
        chk("req_fields_stable", {63'd0, stable}, 64'd1);
        pif.busAckIn = 1'b1;
        @(negedge clk);
        pif.busAckIn = 1'b0;
        repeat (resp_dly) @(negedge clk);
        pif.busRespValidIn = 1'b1;
        pif.busRdataIn = rdata;
        @(negedge clk);
        pif.busRespValidIn = 1'b0;
        chk("done_after_resp", {63'd0, pif.memDoneOut | pif.fetchDoneOut}, 64'd1);
        if (drop_mem)   pif.memReqIn = 1'b0;
        if (drop_fetch) pif.fetchReqIn = 1'b0;
    endtask

    initial begin
        logic [63:0] a, wd;
        logic        wr;
        int          hold, t1, n;
        bit          exp_f [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        pif.fetchReqIn = 0; pif.fetchAddrIn = 0;
        pif.memReqIn = 0; pif.memWriteIn = 0; pif.memAddrIn = 0; pif.memWdataIn = 0;
        pif.busAckIn = 0; pif.busRespValidIn = 0; pif.busRdataIn = 0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busReq", {63'd0, pif.busReqOut}, 64'd0);
        chk("rst_canMemory", {63'd0, pif.canMemoryOut}, 64'd0);
        chk("rst_memRdata", pif.memRdataOut, 64'd0);
        resetN = 1'b1;
        @(negedge clk);
        chk("idle_canMemory", {63'd0, pif.canMemoryOut}, 64'd1);

        // Load with minimum latency
        pif.memReqIn = 1; pif.memWriteIn = 0; pif.memAddrIn = 64'h1000;
        push(1'b0, 1'b0, 64'hDEAD);
        #1 chk("load_canMem_c0", {63'd0, pif.canMemoryOut}, 64'd0);
        @(negedge clk);
        chk("load_busReq_c1", {63'd0, pif.busReqOut}, 64'd1);
        chk("load_busAddr_c1", pif.busAddrOut, 64'h1000);
        chk("load_canMem_c1", {63'd0, pif.canMemoryOut}, 64'd0);
        pif.busAckIn = 1;
        @(negedge clk);
        pif.busAckIn = 0;
        chk("load_busReq_c2", {63'd0, pif.busReqOut}, 64'd0);
        chk("load_canMem_c2", {63'd0, pif.canMemoryOut}, 64'd0);
        pif.busRespValidIn = 1; pif.busRdataIn = 64'hDEAD;
        @(negedge clk);
        pif.busRespValidIn = 0;
        chk("load_done_c3", {63'd0, pif.memDoneOut}, 64'd1);
        chk("load_canMem_c3", {63'd0, pif.canMemoryOut}, 64'd1);
        pif.memReqIn = 0;

        // Store with a 4-cycle ack delay
        @(negedge clk);
        pif.memReqIn = 1; pif.memWriteIn = 1; pif.memAddrIn = 64'h1008; pif.memWdataIn = 64'h55;
        push(1'b0, 1'b0, 64'hDEAD);
        bus_txn(4, 0, 64'hFFFF_0000, 1'b1, 1'b0, a, wr, wd, hold);
        chk("store_req_hold", 64'(hold), 64'd5);
        chk("store_busWrite", {63'd0, wr}, 64'd1);
        chk("store_busWdata", wd, 64'h55);
        chk("store_busAddr", a, 64'h1008);
        pif.memWriteIn = 0;

        // Back-to-back loads, zero-wait bus
        @(negedge clk);
        pif.memReqIn = 1; pif.memAddrIn = 64'h2000;
        push(1'b0, 1'b0, 64'h1111);
        push(1'b0, 1'b0, 64'h2222);
        bus_txn(0, 0, 64'h1111, 1'b0, 1'b0, a, wr, wd, hold);
        t1 = cyc;
        pif.memAddrIn = 64'h2008;
        bus_txn(0, 0, 64'h2222, 1'b1, 1'b0, a, wr, wd, hold);
        chk("b2b_spacing", 64'(cyc - t1), 64'd3);
        chk("b2b_addr2", a, 64'h2008);

        // Starvation: both requesters held
        @(negedge clk);
        pif.fetchAddrIn = 64'h5000; pif.memAddrIn = 64'h6000;
        pif.fetchReqIn = 1; pif.memReqIn = 1;
        for (int i = 0; i < 6; i++) push(exp_f[i], 1'b0, 64'h100 + 64'(i));
        for (int i = 0; i < 6; i++) begin
            bus_txn(0, 0, 64'h100 + 64'(i), i == 5, i == 5, a, wr, wd, hold);
            chk("starve_grant_addr", a, exp_f[i] ? 64'h5000 : 64'h6000);
            if (i == 4) chk("starve_cnt_after_F", 64'(dut.r_starve_cnt), 64'd0);
        end

        // Timeout: ack but no response
        @(negedge clk);
        pif.memReqIn = 1; pif.memAddrIn = 64'h3000;
        push(1'b0, 1'b1, 64'd0);
        n = 0;
        while (!pif.busReqOut && n < 20) begin @(negedge clk); n++; end
        pif.busAckIn = 1;
        @(negedge clk);
        pif.busAckIn = 0;
        n = 0;
        while (!pif.memDoneOut && n < 20) begin @(negedge clk); n++; end
        chk("timeout_latency", 64'(n), 64'd8);
        pif.memReqIn = 0;

        // Response on the timeout cycle wins
        @(negedge clk);
        pif.memReqIn = 1;
        push(1'b0, 1'b0, 64'hBEEF);
        bus_txn(0, 7, 64'hBEEF, 1'b1, 1'b0, a, wr, wd, hold);

        // Reset mid-WAIT
        @(negedge clk);
        pif.memReqIn = 1; pif.memAddrIn = 64'h4000;
        n = 0;
        while (!pif.busReqOut && n < 20) begin @(negedge clk); n++; end
        pif.busAckIn = 1;
        @(negedge clk);
        pif.busAckIn = 0;
        repeat (2) @(negedge clk);
        resetN = 0;
        pif.memReqIn = 0;
        #1;
        chk("rstw_memRdata", pif.memRdataOut, 64'd0);
        chk("rstw_fetchData", pif.fetchDataOut, 64'd0);
        chk("rstw_busAddr", pif.busAddrOut, 64'd0);
        chk("rstw_canMemory", {63'd0, pif.canMemoryOut}, 64'd0);
        chk("rstw_busReq", {63'd0, pif.busReqOut}, 64'd0);
        @(negedge clk);
        resetN = 1;
        pif.busRespValidIn = 1; pif.busRdataIn = 64'h7777;
        @(negedge clk);
        pif.busRespValidIn = 0;
        chk("rstw_no_done", {63'd0, pif.memDoneOut}, 64'd0);
        chk("rstw_idle_canMem", {63'd0, pif.canMemoryOut}, 64'd1);
        repeat (3) @(negedge clk);
        chk("rstw_idle_busReq", {63'd0, pif.busReqOut}, 64'd0);

        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
